rf_wb_ctrl: RTL

Write-back controller that drives the single write port of the 32×32 RISC-V register file. It merges an ALU result channel and a load-unit (LSU) result channel into one registered write per cycle. LSU results are buffered in a small FIFO, and a starvation counter guarantees loads retire. x0 writes are discarded, and an optional bypass network exposes in-flight values to the read ports.

---
 rtl/rf_wb_pkg.sv | 13 +
 rtl/rf_wb_fifo.sv | 54 +++++
 rtl/rf_wb_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
package rf_wb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of write-back requests; exposes its live entries oldest-first
// (index 0 = head) so the bypass network can pick the youngest match.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  wb_req_t                 push_req_i,
  input  logic                    pop_i,
  output wb_req_t                 head_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output wb_req_t [DEPTH-1:0]     entries_o,
  output logic [DEPTH-1:0]        entry_vld_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage is not reset: stale slots are never visible because validity comes from cnt.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= push_req_i;
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = cnt;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_o[i]   = mem[rd_ptr + PTR_W'(i)];
      entry_vld_o[i] = (CNT_W'(i) < cnt);
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: ALU/LSU merge, starvation guard, output register.
// Optional read-port bypass enabled by defining RF_WB_BYPASS_EN.
module rf_wb_ctrl
  import rf_wb_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             alu_valid_i,
  output logic                             alu_ready_o,
  input  logic [RF_ADDR_W-1:0]             alu_rd_i,
  input  logic [RF_DATA_W-1:0]             alu_data_i,
  input  logic                             lsu_valid_i,
  output logic                             lsu_ready_o,
  input  logic [RF_ADDR_W-1:0]             lsu_rd_i,
  input  logic [RF_DATA_W-1:0]             lsu_data_i,
  output logic                             write_enable_o,
  output logic [RF_ADDR_W-1:0]             write_addr_o,
  output logic [RF_DATA_W-1:0]             write_data_o,
  input  logic [RF_ADDR_W-1:0]             read_addr1_i,
  input  logic [RF_ADDR_W-1:0]             read_addr2_i,
  output logic                             fwd1_hit_o,
  output logic                             fwd2_hit_o,
  output logic [RF_DATA_W-1:0]             fwd1_data_o,
  output logic [RF_DATA_W-1:0]             fwd2_data_o,
  output logic [$clog2(LSU_FIFO_DEPTH):0]  fifo_count_o
);

  localparam int CNT_W = $clog2(LSU_FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LSU_FIFO_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  logic [STV_W-1:0]             starve_cnt;
  logic [CNT_W-1:0]             fifo_cnt;
  wb_req_t                      fifo_head;
  wb_req_t [LSU_FIFO_DEPTH-1:0] fifo_ents;
  logic [LSU_FIFO_DEPTH-1:0]    fifo_ent_vld;
  logic                         fifo_empty;
  logic                         alu_wr;
  logic                         enq;
  logic                         deq;
  wb_req_t                      lsu_req;
  logic                         wb_vld_p1;
  wb_req_t                      wb_req_p1;

  assign fifo_empty  = (fifo_cnt == '0);
  assign alu_ready_o = (starve_cnt < LIMIT_C);
  assign lsu_ready_o = (fifo_cnt < DEPTH_C);

  // rd==0 results complete their handshake but are dropped here.
  assign alu_wr  = alu_valid_i && alu_ready_o && (alu_rd_i != REG_ZERO);
  assign enq     = lsu_valid_i && lsu_ready_o && (lsu_rd_i != REG_ZERO);
  assign deq     = !alu_wr && !fifo_empty;
  assign lsu_req = '{rd: lsu_rd_i, data: lsu_data_i};

  rf_wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (enq),
    .push_req_i  (lsu_req),
    .pop_i       (deq),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt),
    .entries_o   (fifo_ents),
    .entry_vld_o (fifo_ent_vld)
  );

  assign fifo_count_o = fifo_cnt;

  // Saturates at STARVE_LIMIT: at that value the ALU is blocked, forcing a dequeue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt <= '0;
    end else if (fifo_empty || deq) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // ---- stage p1: registered write port ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_vld_p1 <= 1'b0;
      wb_req_p1 <= '0;
    end else if (alu_wr) begin
      wb_vld_p1 <= 1'b1;
      wb_req_p1 <= '{rd: alu_rd_i, data: alu_data_i};
    end else if (deq) begin
      wb_vld_p1 <= 1'b1;
      wb_req_p1 <= fifo_head;
    end else begin
      wb_vld_p1 <= 1'b0;
    end
  end

  assign write_enable_o = wb_vld_p1;
  assign write_addr_o   = wb_req_p1.rd;
  assign write_data_o   = wb_req_p1.data;

`ifdef RF_WB_BYPASS_EN
  // Returns {hit, data}; output stage beats FIFO, youngest FIFO entry beats older ones.
  function automatic logic [RF_DATA_W:0] fwd_lookup(
    input logic [RF_ADDR_W-1:0]       addr,
    input logic                       out_vld,
    input wb_req_t                    out_req,
    input wb_req_t [LSU_FIFO_DEPTH-1:0] ents,
    input logic [LSU_FIFO_DEPTH-1:0]  vld
  );
    logic                 hit;
    logic [RF_DATA_W-1:0] data;
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
      if (vld[i] && (ents[i].rd == addr)) begin
        hit  = 1'b1;
        data = ents[i].data;
      end
    end
    if (out_vld && (out_req.rd == addr)) begin
      hit  = 1'b1;
      data = out_req.data;
    end
    if (addr == REG_ZERO) begin
      hit  = 1'b0;
      data = '0;
    end
    return {hit, data};
  endfunction

  always_comb begin
    {fwd1_hit_o, fwd1_data_o} = fwd_lookup(read_addr1_i, wb_vld_p1, wb_req_p1, fifo_ents, fifo_ent_vld);
    {fwd2_hit_o, fwd2_data_o} = fwd_lookup(read_addr2_i, wb_vld_p1, wb_req_p1, fifo_ents, fifo_ent_vld);
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{read_addr1_i, read_addr2_i, fifo_ents, fifo_ent_vld};

  assign fwd1_hit_o  = 1'b0;
  assign fwd2_hit_o  = 1'b0;
  assign fwd1_data_o = '0;
  assign fwd2_data_o = '0;
`endif

endmodule
